// File: rtl/ram_pkg.sv
// Shared definitions for the pipelined single-port RAM: lane count, response
// buffer sizing, latency legality and the {err, rdata} response layout.
package ram_pkg;

  localparam int RAM_DATA_WIDTH = 32;

  typedef struct packed {
    logic                      err;
    logic [RAM_DATA_WIDTH-1:0] rdata;
  } ram_rsp_t;

  localparam int RAM_RSP_WIDTH = $bits(ram_rsp_t);

  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

  // One slot per in-flight pipeline stage plus one so a full-rate stream never stalls
  function automatic int resp_depth(input int read_latency);
    return read_latency + 1;
  endfunction

  function automatic bit latency_ok(input int read_latency);
    return (read_latency >= 1) && (read_latency <= 3);
  endfunction

  function automatic int rsp_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Synchronous response FIFO with modulo-DEPTH pointers; count feeds the
// request credit logic. Push into a full FIFO is taken only alongside a pop.
module ram_rsp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  // Zero when empty so rsp_rdata/rsp_err read as 0 outside a valid response
  assign pop_data = empty ? '0 : store[rd_ptr];

endmodule

// File: rtl/pipelined_sp_ram.sv
// Single-port RAM with valid/ready request and response channels, byte-lane
// writes, READ_LATENCY-deep read pipeline and a credit-gated response buffer.
// Optional per-lane even parity: define PIPELINED_SP_RAM_PARITY_EN.
module pipelined_sp_ram
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int DEPTH        = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);

  localparam int LANES      = lane_count(DATA_WIDTH);
  localparam int RESP_DEPTH = resp_depth(READ_LATENCY);
  localparam int RSP_W      = rsp_width(DATA_WIDTH);
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W      = $clog2(RESP_DEPTH + 1);
  localparam int OCC_W      = CNT_W + 1;

  if (!latency_ok(READ_LATENCY) || (DATA_WIDTH % 8 != 0)) begin : g_bad_config
    $error("pipelined_sp_ram: READ_LATENCY must be 1..3 and DATA_WIDTH a multiple of 8");
  end

  logic                  accept;
  logic                  wr_en;
  logic                  rd_en;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_err;

  logic [READ_LATENCY-1:0] st_valid;
  logic [RSP_W-1:0]        st_data [READ_LATENCY];

  logic [RSP_W-1:0] fifo_data;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [OCC_W-1:0] inflight;
  logic [OCC_W-1:0] occupancy;
  logic             rsp_pop;

  assign accept   = req_valid && req_ready;
  assign wr_en    = accept && req_we && in_range;
  assign rd_en    = accept && !req_we;
  assign in_range = ({1'b0, req_addr} < (ADDR_WIDTH+1)'(DEPTH));
  assign idx      = req_addr[IDX_W-1:0];

`ifdef PIPELINED_SP_RAM_PARITY_EN
  logic [LANES-1:0] par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < LANES; k++) begin
        if (req_be[k]) begin
          mem[idx][8*k +: 8] <= req_wdata[8*k +: 8];
          par_mem[idx][k]    <= ^req_wdata[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = mem[idx];
    rd_data = in_range ? rd_word : '0;
    rd_err  = !in_range;
    for (int k = 0; k < LANES; k++) begin
      if (in_range && ((^rd_word[8*k +: 8]) != par_mem[idx][k])) rd_err = 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < LANES; k++) begin
        if (req_be[k]) mem[idx][8*k +: 8] <= req_wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem[idx];
    rd_data = in_range ? rd_word : '0;
    rd_err  = !in_range;
  end
`endif

  // Data is captured at acceptance, so a read right after a write sees the new word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) st_data[i] <= '0;
    end else begin
      st_valid[0] <= rd_en;
      st_data[0]  <= {rd_err, rd_data};
      for (int i = 1; i < READ_LATENCY; i++) begin
        st_valid[i] <= st_valid[i-1];
        st_data[i]  <= st_data[i-1];
      end
    end
  end

  ram_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RESP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (st_valid[READ_LATENCY-1]),
    .push_data (st_data[READ_LATENCY-1]),
    .pop       (rsp_ready),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_valid              = !fifo_empty;
  assign {rsp_err, rsp_rdata}   = fifo_data;
  assign rsp_pop                = rsp_valid && rsp_ready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + OCC_W'(st_valid[i]);
  end

  // A response leaving this cycle frees its slot immediately
  assign occupancy = inflight + OCC_W'(fifo_count) - OCC_W'(rsp_pop);
  assign req_ready = !rst && (occupancy < OCC_W'(RESP_DEPTH));

endmodule

// File: tb/tb_pipelined_sp_ram.sv
// Scoreboard bench for pipelined_sp_ram (READ_LATENCY=2): the driver queues
// expected responses, an independent monitor checks them on each handshake.
module tb_pipelined_sp_ram;

  localparam int RL    = 2;
  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 32;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            due;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model [DEPTH];
  int            cyc = 0;
  int            n_compared = 0;
  int            n_mismatched = 0;

  pipelined_sp_ram #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .DEPTH        (DEPTH),
    .READ_LATENCY (RL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: compares the head of the scoreboard while a response is shown
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_rsp", rsp_valid, 0);
      end else begin
        checkOutput("rsp_rdata", rsp_rdata, exp_q[0].data);
        checkOutput("rsp_err", rsp_err, exp_q[0].err);
        if (rsp_ready) begin
          if (exp_q[0].due >= 0) checkOutput("rsp_latency", cyc, exp_q[0].due);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic [3:0] be, input logic [DW-1:0] exp_data, input logic exp_err,
                               input bit check_lat, output int stalls);
    exp_t e;
    stalls = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    #1;
    while (!req_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (!req_ready) begin
      checkOutput("req_timeout", req_ready, 1);
    end else if (!we) begin
      e.data = exp_data;
      e.err  = exp_err;
      e.due  = check_lat ? cyc + 1 + RL : -1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic doWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] be);
    int s;
    if (addr < DEPTH) begin
      for (int k = 0; k < 4; k++) if (be[k]) model[addr][8*k +: 8] = data[8*k +: 8];
    end
    applyStimulus(1'b1, addr, data, be, '0, 1'b0, 1'b0, s);
  endtask

  task automatic doRead(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data, input logic exp_err,
                        input bit check_lat, output int stalls);
    applyStimulus(1'b0, addr, '0, 4'h0, exp_data, exp_err, check_lat, stalls);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) checkOutput(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s;
    int total;
    int acc;
    int seen;
    logic [AW-1:0] bp_addr [4];
    logic exp_par_err;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
    bp_addr[0] = 0; bp_addr[1] = 5; bp_addr[2] = 7; bp_addr[3] = 9;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 0);
    checkOutput("reset_rsp_err", rsp_err, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("ready_after_reset", req_ready, 1);

    doWrite(0, 32'hA5A5_0000, 4'hF);
    doWrite(3, 32'h0BAD_F00D, 4'hF);
    doWrite(7, 32'h1111_2222, 4'hF);

    // Byte lanes
    doWrite(5, 32'hFFFF_FFFF, 4'hF);
    doWrite(5, 32'h1234_5678, 4'b0101);
    doRead(5, 32'hFF34_FF78, 1'b0, 1'b0, s);

    // Read directly after write returns new data
    doWrite(9, 32'hCAFE_BABE, 4'hF);
    doRead(9, 32'hCAFE_BABE, 1'b0, 1'b0, s);

    // Out of range
    doWrite(32, 32'hDEAD_BEEF, 4'hF);
    doRead(32, 32'h0000_0000, 1'b1, 1'b0, s);
    doRead(0, 32'hA5A5_0000, 1'b0, 1'b0, s);
    waitDrain("drain_basic");

    // Back-pressure: three credits with READ_LATENCY=2
    rsp_ready = 1'b0;
    acc = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = bp_addr[acc % 4];
      #1;
      if (req_ready) begin
        exp_q.push_back('{data: model[bp_addr[acc % 4]], err: 1'b0, due: -1});
        acc++;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
    checkOutput("bp_accepted", acc, 3);
    checkOutput("bp_ready_low", req_ready, 0);
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_ready_on_pop", req_ready, 1);
    checkOutput("bp_valid_on_pop", rsp_valid, 1);
    waitDrain("drain_bp");

    // Full rate
    for (int i = 16; i < 24; i++) doWrite(AW'(i), (32'h0101_0101 * i) ^ 32'hF0F0_0000, 4'hF);
    total = 0;
    for (int i = 0; i < 64; i++) begin
      doRead(AW'(16 + i % 8), model[16 + i % 8], 1'b0, 1'b1, s);
      total += s;
    end
    checkOutput("fullrate_stalls", total, 0);
    waitDrain("drain_fullrate");

    // Corrupt one stored bit of addr 3
`ifdef PIPELINED_SP_RAM_PARITY_EN
    exp_par_err = 1'b1;
`else
    exp_par_err = 1'b0;
`endif
    @(negedge clk);
    dut.mem[3][0] = ~dut.mem[3][0];
    doRead(3, 32'h0BAD_F00C, exp_par_err, 1'b0, s);
    waitDrain("drain_parity");

    // Reset mid-stream: two reads in flight are discarded
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5;
    @(posedge clk);
    #1 req_addr = 0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midreset_req_ready", req_ready, 0);
    checkOutput("midreset_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checkOutput("midreset_no_rsp", seen, 0);
    doRead(5, 32'hFF34_FF78, 1'b0, 1'b0, s);
    doRead(7, 32'h1111_2222, 1'b0, 1'b0, s);
    waitDrain("drain_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
